// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder sequencing one 4-bit CLA slice per clock.
// Optional subtract mode (Sub port) is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN.
module Carry_Lookahead_Adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = A & B;
    assign p = A ^ B;
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign S = p ^ c[3:0];
    assign Cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = $clog2(NIB);

    if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [3:0]       na, nb, ns;
    logic             nc, sub;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign sub = Sub;
`else
    assign sub = 1'b0;
`endif

    assign na = opa[4*idx +: 4];
    assign nb = opb[4*idx +: 4];

    Carry_Lookahead_Adder cla (.A(na), .B(nb), .Cin(carry), .S(ns), .Cout(nc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            S        <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opa   <= A;
                    opb   <= sub ? ~B : B;
                    carry <= sub ? 1'b1 : Cin;
                    S     <= '0;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    S[4*idx +: 4] <= ns;
                    carry         <= nc;
                    if (idx == IW'(NIB - 1)) begin
                        Cout     <= nc;
                        // carry into the MSB xor carry out of it
                        Overflow <= (opa[WIDTH-1] ^ opb[WIDTH-1] ^ ns[3]) ^ nc;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized self-checking bench against an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         Cin = 1'b0;
    logic         sub_i = 1'b0;
    logic         busy, done, Cout, Overflow;
    logic [W-1:0] S;
    int           pass = 0, total = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .Sub(sub_i),
`endif
        .busy(busy), .done(done), .S(S), .Cout(Cout), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic cin, sb);
        logic [W-1:0] bb;
        logic [W:0]   r;
        logic         ov;
        bb = sb ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + (W+1)'(sb ? 1'b1 : cin);
        ov = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {ov, r};
    endfunction

    task automatic do_op(input logic [W-1:0] a, b, input logic cin, sb,
                         output logic [W-1:0] s, output logic co, ov,
                         output int lat, output int busy_n, output logic done_after);
        @(negedge clk);
        A = a; B = b; Cin = cin; sub_i = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; Cin = $urandom;
        lat = 0; busy_n = 0;
        while (!done && lat < 20) begin
            busy_n += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        s = S; co = Cout; ov = Overflow;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy, done, S, Cout, Overflow} !== '0) $display("FAIL reset: busy=%b done=%b S=%h Cout=%b Ovf=%b required all 0", busy, done, S, Cout, Overflow); else pass++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_carry_chain;
        logic [W-1:0] s; logic co, ov, da; int lat, bn;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, bn, da);
        total++; if (lat !== NIB) $display("FAIL carry_latency: got %0d required %0d", lat, NIB); else pass++;
        total++; if (bn !== NIB) $display("FAIL carry_busy_cycles: got %0d required %0d", bn, NIB); else pass++;
        total++; if ({ov, co, s} !== {1'b0, 1'b1, 16'h0000}) $display("FAIL carry_result: got S=%h Cout=%b Ovf=%b required S=0000 Cout=1 Ovf=0", s, co, ov); else pass++;
        total++; if (da !== 1'b0) $display("FAIL done_one_cycle: done=%b after pulse, required 0", da); else pass++;
        total++; if ({S, Cout} !== {16'h0000, 1'b1}) $display("FAIL result_hold: S=%h Cout=%b required S=0000 Cout=1", S, Cout); else pass++;
    endtask

    task automatic test_overflow_cin;
        logic [W-1:0] s; logic co, ov, da; int lat, bn;
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, s, co, ov, lat, bn, da);
        total++; if ({ov, co, s} !== {1'b1, 1'b0, 16'h8000}) $display("FAIL overflow: got S=%h Cout=%b Ovf=%b required S=8000 Cout=0 Ovf=1", s, co, ov); else pass++;
        do_op(16'h1239, 16'h0011, 1'b1, 1'b0, s, co, ov, lat, bn, da);
        total++; if ({ov, co, s} !== {1'b0, 1'b0, 16'h124B}) $display("FAIL cin_add: got S=%h Cout=%b Ovf=%b required S=124b Cout=0 Ovf=0", s, co, ov); else pass++;
    endtask

    task automatic test_start_ignored;
        int pulses = 0;
        logic [W-1:0] s = 'x; logic co = 1'bx;
        @(negedge clk);
        A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; sub_i = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); A = 16'h0001; B = 16'h0001; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; s = S; co = Cout; end
        end
        total++; if (pulses !== 1) $display("FAIL ignore_start_pulses: got %0d required 1", pulses); else pass++;
        total++; if ({co, s} !== {1'b1, 16'h0000}) $display("FAIL ignore_start_result: got S=%h Cout=%b required S=0000 Cout=1", s, co); else pass++;
    endtask

    task automatic test_reset_midop;
        logic [W-1:0] s; logic co, ov, da; int lat, bn, pulses = 0;
        @(negedge clk);
        A = 16'h1111; B = 16'h1111; Cin = 1'b0; sub_i = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (S !== 16'h0022) $display("FAIL midop_partial: S=%h required 0022", S); else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, done, S, Cout, Overflow} !== '0) $display("FAIL midop_async_reset: busy=%b done=%b S=%h Cout=%b Ovf=%b required all 0", busy, done, S, Cout, Overflow); else pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL midop_no_done: got %0d pulses required 0", pulses); else pass++;
        do_op(16'h00F0, 16'h0010, 1'b0, 1'b0, s, co, ov, lat, bn, da);
        total++; if ({co, s} !== {1'b0, 16'h0100}) $display("FAIL after_reset_op: got S=%h Cout=%b required S=0100 Cout=0", s, co); else pass++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] s, a, b; logic co, ov, da, cin; int lat, bn;
        logic [W+1:0] e;
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 16'h8000 : 16'($urandom); b = (i == 0) ? 16'h8000 : 16'($urandom); cin = 1'($urandom);
            e = model(a, b, cin, 1'b0);
            do_op(a, b, cin, 1'b0, s, co, ov, lat, bn, da);
            total++; if ({ov, co, s} !== e || lat !== NIB) $display("FAIL back_to_back[%0d]: got Ovf=%b Cout=%b S=%h lat=%0d required Ovf=%b Cout=%b S=%h lat=%0d", i, ov, co, s, lat, e[W+1], e[W], e[W-1:0], NIB); else pass++;
        end
    endtask

    task automatic test_random;
        logic [W-1:0] s, a, b; logic co, ov, da, cin, sb; int lat, bn;
        logic [W+1:0] e;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            e = model(a, b, cin, sb);
            do_op(a, b, cin, sb, s, co, ov, lat, bn, da);
            total++; if ({ov, co, s} !== e) $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: got Ovf=%b Cout=%b S=%h required Ovf=%b Cout=%b S=%h", i, a, b, cin, sb, ov, co, s, e[W+1], e[W], e[W-1:0]); else pass++;
            total++; if (lat !== NIB || da !== 1'b0) $display("FAIL random_timing[%0d]: lat=%0d done_after=%b required lat=%0d done_after=0", i, lat, da, NIB); else pass++;
        end
    endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    task automatic test_subtract;
        logic [W-1:0] s; logic co, ov, da; int lat, bn;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov, lat, bn, da);
        total++; if ({ov, co, s} !== {1'b0, 1'b0, 16'hFFFE}) $display("FAIL sub_borrow: got S=%h Cout=%b Ovf=%b required S=fffe Cout=0 Ovf=0", s, co, ov); else pass++;
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat, bn, da);
        total++; if ({ov, co, s} !== {1'b1, 1'b1, 16'h7FFF}) $display("FAIL sub_overflow: got S=%h Cout=%b Ovf=%b required S=7fff Cout=1 Ovf=1", s, co, ov); else pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_carry_chain;
        test_overflow_cin;
        test_start_ignored;
        test_reset_midop;
        test_back_to_back;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        test_subtract;
`endif
        test_random;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
